// File: rtl/icache_dm_refill_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states, NOP, geometry helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package icache_dm_refill_pkg;

    // Refill controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } refill_state_e;

    // Instruction returned whenever the output is not a valid hit (addi x0,x0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default geometry
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_NUM_LINES      = 32;
    localparam int DEF_WORDS_PER_LINE = 4;

    // Ceiling log2 usable in constant expressions
    function automatic int clog2_f(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line-refill controller: latches the missing line, runs the mem_req/mem_gnt handshake, counts beats.
// Latency: miss seen in IDLE -> mem_req next cycle; grant -> FILL next cycle; last beat -> IDLE next cycle.
// Backpressure: mem_req held until mem_gnt; beats accepted whenever mem_rvalid is high in FILL.
module icache_refill_fsm
    import icache_dm_refill_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int IDX_W          = 5,
    parameter int OFF_W          = 4,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_W-OFF_W-1:0]    pc_line,
    input  logic                       pc_valid,
    input  logic                       lookup_hit,
    input  logic                       flush,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       idle,
    output logic                       miss_start,
    output logic                       wr_en,
    output logic [IDX_W-1:0]           wr_idx,
    output logic [OFF_W-3:0]           wr_word,
    output logic [ADDR_W-OFF_W-IDX_W-1:0] wr_tag,
    output logic                       validate
);

    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

    refill_state_e     state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic              abort_q, abort_d;
    logic              mem_req_q, mem_req_d;

    // Next-state logic and per-cycle strobes towards the arrays
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        beat_d     = beat_q;
        abort_d    = abort_q;
        mem_req_d  = mem_req_q;
        miss_start = 1'b0;
        wr_en      = 1'b0;
        validate   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                // A flush in the same cycle suppresses the miss; it is retried next cycle
                if (pc_valid && !lookup_hit && !flush) begin
                    miss_start = 1'b1;
                    line_d     = pc_line;
                    mem_req_d  = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    beat_d    = '0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (flush) begin
                    abort_d = 1'b1;
                end
                if (mem_rvalid) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + WORD_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        // A flush on the final beat must leave the line invalid
                        validate = !abort_q && !flush;
                        abort_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Controller registers; reset abandons any burst in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            beat_q    <= '0;
            abort_q   <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            abort_q   <= abort_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = {line_q, {OFF_W{1'b0}}};
    assign idle     = (state_q == ST_IDLE);
    assign wr_idx   = line_q[IDX_W-1:0];
    assign wr_tag   = line_q[LINE_W-1:IDX_W];
    assign wr_word  = beat_q;

endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache: combinational lookup, whole-line refill, single-cycle flush.
// Latency: hit returns the word in the same cycle; miss penalty >= 1 + grant + WORDS_PER_LINE + 1 cycles.
// Backpressure: stall_cache_instrucoes holds IF while a valid fetch is not a hit in IDLE.
module icache_dm_refill
    import icache_dm_refill_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              stall_cache_instrucoes,
    output logic [31:0]       instrucao_do_processador,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       miss_count
);

    localparam int OFF_W  = clog2_f(WORDS_PER_LINE) + 2;
    localparam int IDX_W  = clog2_f(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;

    // Address fields of the current fetch
    logic [IDX_W-1:0]        pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic [WORD_W-1:0]       pc_word;
    logic [ADDR_W-OFF_W-1:0] pc_line;
    logic                    unused_pc_bits;

    assign pc_idx         = pc[OFF_W +: IDX_W];
    assign pc_tag         = pc[ADDR_W-1 -: TAG_W];
    assign pc_word        = pc[2 +: WORD_W];
    assign pc_line        = pc[ADDR_W-1:OFF_W];
    assign unused_pc_bits = ^pc[1:0];

    // Storage: valid is a flat register so flush clears it in one edge; tag/data are never reset
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];
    logic [31:0]          miss_count_q, miss_count_d;

    // Controller strobes
    logic              fsm_idle;
    logic              miss_start;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [WORD_W-1:0] wr_word;
    logic [TAG_W-1:0]  wr_tag;
    logic              validate;

    logic lookup_hit;
    logic hit_idle;

    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign hit_idle   = fsm_idle && lookup_hit;

    assign stall_cache_instrucoes   = pc_valid && !hit_idle;
    assign instrucao_do_processador = hit_idle ? data_q[pc_idx][pc_word] : NOP_INSTR;
    assign miss_count               = miss_count_q;

    icache_refill_fsm #(
        .ADDR_W         (ADDR_W),
        .IDX_W          (IDX_W),
        .OFF_W          (OFF_W),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill_fsm (
        .clock      (clock),
        .reset      (reset),
        .pc_line    (pc_line),
        .pc_valid   (pc_valid),
        .lookup_hit (lookup_hit),
        .flush      (flush),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .idle       (fsm_idle),
        .miss_start (miss_start),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_word    (wr_word),
        .wr_tag     (wr_tag),
        .validate   (validate)
    );

    // Valid bits: flush beats a same-edge validate; miss counter advances on each refill start
    always_comb begin
        valid_d = valid_q;
        if (validate) begin
            valid_d[wr_idx] = 1'b1;
        end
        if (flush) begin
            valid_d = '0;
        end
        miss_count_d = miss_count_q + 32'(miss_start);
    end

    // Valid and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            miss_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Line storage: beats land word by word, the tag is written when the line is validated
    always_ff @(posedge clock) begin
        if (wr_en) begin
            data_q[wr_idx][wr_word] <= mem_rdata;
        end
        if (validate) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed bench for icache_dm_refill with an in-line memory responder and an instruction scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: the responder grants one idle cycle after mem_req is seen, then streams beats back-to-back.
module tb_icache_dm_refill;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        stall;
    logic [31:0] instr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] miss_count;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    icache_dm_refill #(
        .ADDR_W         (32),
        .NUM_LINES      (32),
        .WORDS_PER_LINE (4)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .pc                       (pc),
        .pc_valid                 (pc_valid),
        .flush                    (flush),
        .stall_cache_instrucoes   (stall),
        .instrucao_do_processador (instr),
        .mem_req                  (mem_req),
        .mem_addr                 (mem_addr),
        .mem_gnt                  (mem_gnt),
        .mem_rvalid               (mem_rvalid),
        .mem_rdata                (mem_rdata),
        .miss_count               (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", name, obs, exp);
        end
    endtask

    // Drive a fetch; when a hit is eventually expected, queue the word it must return
    task automatic fetch(input logic [31:0] addr, input bit expect_word, input logic [31:0] word);
        pc       = addr;
        pc_valid = 1'b1;
        if (expect_word) exp_q.push_back(word);
        #1;
    endtask

    // Output side of the scoreboard: a hit must show no stall and the queued word
    task automatic hit_check(input string name);
        chk({name, "_stall"}, {31'd0, stall}, 32'd0);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=%08h", name, instr);
        end else begin
            chk(name, instr, exp_q.pop_front());
        end
    endtask

    // Memory responder for one burst; flush_beat/rst_beat = -1 disables that event
    task automatic refill(input logic [31:0] addr, input logic [31:0] base,
                          input int flush_beat, input int rst_beat);
        tick();
        chk("req_up", {31'd0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, addr);
        chk("req_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("req_hold", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            chk("fill_stall", {31'd0, stall}, {31'd0, pc_valid});
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(b);
            flush      = (b == flush_beat);
            if (b == rst_beat) begin
                reset    = 1'b1;
                pc_valid = 1'b0;
            end
            tick();
            mem_rvalid = 1'b0;
            flush      = 1'b0;
            if (b == rst_beat) begin
                reset = 1'b0;
                #1;
                return;
            end
        end
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        pc         = 32'h0;
        pc_valid   = 1'b0;
        flush      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_miss", miss_count, 32'd0);
        chk("rst_instr", instr, NOP);

        // Cold miss then same-line hit
        fetch(32'h100, 1'b1, 32'hA0);
        chk("cold_stall", {31'd0, stall}, 32'd1);
        chk("cold_instr", instr, NOP);
        chk("cold_noreq", {31'd0, mem_req}, 32'd0);
        refill(32'h100, 32'hA0, -1, -1);
        hit_check("cold_hit");
        fetch(32'h10C, 1'b1, 32'hA3);
        hit_check("cold_word3");
        chk("cold_miss", miss_count, 32'd1);

        // Conflict on index 16
        fetch(32'h300, 1'b1, 32'hB0);
        chk("conf_stall", {31'd0, stall}, 32'd1);
        refill(32'h300, 32'hB0, -1, -1);
        hit_check("conf_hit300");
        fetch(32'h104, 1'b1, 32'hC1);
        chk("conf_stall2", {31'd0, stall}, 32'd1);
        refill(32'h100, 32'hC0, -1, -1);
        hit_check("conf_hit104");
        chk("conf_miss", miss_count, 32'd3);

        // Flush in IDLE while hitting
        fetch(32'h100, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fidle_stall", {31'd0, stall}, 32'd1);
        exp_q.push_back(32'hD0);
        refill(32'h100, 32'hD0, -1, -1);
        hit_check("fidle_hit");
        chk("fidle_miss", miss_count, 32'd4);

        // Flush during FILL on beat 2: burst consumed, line left invalid, fresh request follows
        fetch(32'h200, 1'b1, 32'hF0);
        refill(32'h200, 32'hE0, 2, -1);
        chk("ffill_stall", {31'd0, stall}, 32'd1);
        chk("ffill_instr", instr, NOP);
        chk("ffill_noreq", {31'd0, mem_req}, 32'd0);
        chk("ffill_miss", miss_count, 32'd5);
        refill(32'h200, 32'hF0, -1, -1);
        hit_check("ffill_hit");
        chk("ffill_miss2", miss_count, 32'd6);

        // Reset during FILL, then a stray beat in IDLE
        fetch(32'h400, 1'b0, 32'h0);
        refill(32'h400, 32'h40, -1, 1);
        chk("rfill_req", {31'd0, mem_req}, 32'd0);
        chk("rfill_miss", miss_count, 32'd0);
        chk("rfill_stall", {31'd0, stall}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_req", {31'd0, mem_req}, 32'd0);
        fetch(32'h100, 1'b1, 32'h50);
        chk("rfill_stall2", {31'd0, stall}, 32'd1);
        refill(32'h100, 32'h50, -1, -1);
        hit_check("rfill_hit");
        chk("rfill_miss2", miss_count, 32'd1);

        // Idle fetch port with an uncached pc
        pc       = 32'h700;
        pc_valid = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_instr", instr, NOP);
        tick();
        chk("idle_noreq", {31'd0, mem_req}, 32'd0);

        // Flush suppresses a miss start in IDLE
        pc_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("fsup_stall", {31'd0, stall}, 32'd1);
        tick();
        flush = 1'b0;
        chk("fsup_noreq", {31'd0, mem_req}, 32'd0);
        chk("fsup_miss", miss_count, 32'd1);

        // Flush on the last beat: line must stay invalid
        refill(32'h700, 32'h70, 3, -1);
        chk("flast_stall", {31'd0, stall}, 32'd1);
        chk("flast_instr", instr, NOP);
        pc_valid = 1'b0;
        tick();
        chk("flast_noreq", {31'd0, mem_req}, 32'd0);
        chk("flast_miss", miss_count, 32'd2);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
